adc_spi_sim: RTL and testbench
==============================

# adc_spi_sim

Simulation-only ADC model: an SPI slave that emulates a serial ADC for the control-loop simulation top, with the conversion value supplied by the simulator. A falling edge on the conversion/select line raises a request to the simulator. The block latches the supplied word when the simulator answers, then shifts it out MSB-first on `miso` in the configured SPI mode. It sits between the control loop's ADC SPI master and the simulator's value/handshake signals, and flags protocol violations on `err`.

## Interface
- `WID`, 18: conversion word width in bits.
- `WID_LEN`, 5: bit-counter width; requires `WID < 2**WID_LEN`.
- `POLARITY`, 1: SPI CPOL, the idle level of `sck`.
- `PHASE`, 0: SPI CPHA.
  - 0: slave drives on trailing edge, master samples on leading edge.
  - 1: slave drives on leading edge, master samples on trailing edge.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_L`  in  1  asynchronous, active-low reset.
- `indat`  in  WID  conversion value from the simulator; sampled only while `fulfilled` is high in WAIT_DATA.
- `request`  out  1  asks the simulator for a value.
- `fulfilled`  in  1  simulator answer; `indat` is valid while it is high.
- `err`  out  1  sticky protocol-error flag.
- `miso`  out  1  serial data to the master.
- `sck`  in  1  SPI clock from the master (same clock domain).
- `ss_L`  in  1  active-low conversion/select from the master.

## Operation
- Edge detection:
  - `sck` and `ss_L` are registered each cycle into `sck_q` and `ss_q`. Reset values: `sck_q = POLARITY`, `ss_q = 1`.
  - Leading edge: `sck_q == POLARITY` and `sck != POLARITY`.
  - Trailing edge: the reverse transition.
- Reset (async, `rst_L = 0`): `request = 0`, `err = 0`, `miso = 0`, state IDLE, shift register 0, bit count 0.
- IDLE:
  - `miso = 0`.
  - On `ss_L` falling (`ss_q = 1`, `ss_L = 0`): set `request = 1`, clear `err`, go to WAIT_DATA.
- WAIT_DATA:
  - `request` is held at 1.
  - When `fulfilled = 1`: load the shift register with `indat`, clear `request`, set bit count to 0, go to SHIFT. If `PHASE = 0`, also set `miso = indat[WID-1]` on the same edge.
  - Any `sck` edge in this state sets `err = 1`; the state is unchanged.
  - `ss_L` rising in this state: `request = 0`, go to IDLE, no error.
- SHIFT:
  - PHASE 0:
    - Trailing edge: shift left and set `miso` to the new MSB.
    - Leading edge: increment the bit count.
  - PHASE 1:
    - Leading edge: set `miso` to the MSB, then shift left.
    - Trailing edge: increment the bit count.
  - When the count reaches `WID`, go to DONE.
  - `ss_L` rising before `WID` bits: `err = 1`, `miso = 0`, go to IDLE.
- DONE:
  - Any further `sck` edge sets `err = 1`.
  - `ss_L` rising: `miso = 0`, go to IDLE.
- `fulfilled` is ignored outside WAIT_DATA.
- `err` holds until the next `ss_L` falling edge or reset.

## Timing
- `request` rises on the first `clk` edge where `ss_L = 0` and `ss_q = 1`; it is registered, so it is visible 1 cycle after `ss_L` is seen low.
- `request` falls, and data is latched, on the same edge at which `fulfilled` is sampled high.
- `miso` updates on the `clk` edge at which an `sck` transition is first seen, i.e. one `clk` after `sck` changes.
- Master constraints:
  - `sck` high and low phases must each be ≥ 2 `clk` cycles.
  - `ss_L` must fall at least 1 `clk` before the first `sck` edge after `fulfilled`.
- Simultaneous events:
  - `ss_L` rising wins over an `sck` edge in the same cycle.
  - `fulfilled` together with an `sck` edge in WAIT_DATA: the data is latched and `err = 1`.
- Reset mid-transfer: all outputs go to 0 immediately (async) and the state returns to IDLE.

## Test plan
- Mode 0 (`POLARITY = 0`, `PHASE = 0`), `indat = 18'h2A5C3`:
  - `ss_L` falls → `request = 1` next cycle.
  - `fulfilled` pulse → `request = 0` and `miso = 1`.
  - 18 `sck` pulses sampled on rising edges yield `18'h2A5C3`; `err = 0`.
- Mode 3 (`POLARITY = 1`, `PHASE = 1`), `indat = 18'h20001`: the bits sampled on rising (trailing) edges yield `18'h20001`, and `err = 0`.
- `sck` toggled while `request = 1` → `err = 1`; the next `ss_L` falling edge clears `err` to 0.
- `ss_L` raised after 10 bits → `err = 1`, `miso = 0`, back to IDLE. A fresh transfer with `indat = 18'h3FFFF` then reads `18'h3FFFF` with `err = 0`.
- 19th `sck` pulse before `ss_L` rises → `err = 1`.
- `rst_L` asserted at bit 7 → `request`, `err` and `miso` all 0 at once. The next transfer with `indat = 18'h00001` is correct.

Source files
------------

// File: rtl/adc_spi_sim_if.sv
// Bundles the ADC model's simulator handshake and SPI pins.
// The master modport drives both the simulator value and the SPI master signals.
interface adc_spi_sim_if #(
   parameter int unsigned WID = 18
) ();
   logic [WID-1:0] indat;
   logic           request;
   logic           fulfilled;
   logic           err;
   logic           miso;
   logic           sck;
   logic           ss_L;

   modport master (
      output indat, fulfilled, sck, ss_L,
      input  request, err, miso
   );

   modport slave (
      input  indat, fulfilled, sck, ss_L,
      output request, err, miso
   );
endinterface

// File: rtl/adc_spi_sim.sv
// Simulation ADC model: SPI slave that asks the simulator for a conversion word
// on each select, then shifts it out MSB-first in the configured CPOL/CPHA mode.
module adc_spi_sim #(
   parameter int unsigned WID      = 18,
   parameter int unsigned WID_LEN  = 5,
   parameter bit          POLARITY = 1'b1,
   parameter bit          PHASE    = 1'b0
) (
   input logic          clk,
   input logic          rst_L,
   adc_spi_sim_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StWait, StShift, StDone} state_e;

   state_e               state_q, state_d;
   logic [WID-1:0]       shreg_q, shreg_d;
   logic [WID_LEN-1:0]   cnt_q, cnt_d;
   logic                 request_q, request_d;
   logic                 err_q, err_d;
   logic                 miso_q, miso_d;
   logic                 sck_q, sck_d;
   logic                 ss_q, ss_d;

   logic                 lead, trail, ss_fall, ss_rise;
   logic [WID_LEN-1:0]   cnt_inc;

   assign lead    = (sck_q == POLARITY) && (bus.sck != POLARITY);
   assign trail   = (sck_q != POLARITY) && (bus.sck == POLARITY);
   assign ss_fall = ss_q && !bus.ss_L;
   assign ss_rise = !ss_q && bus.ss_L;
   assign cnt_inc = cnt_q + WID_LEN'(1);

   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      request_d = request_q;
      err_d     = err_q;
      miso_d    = miso_q;
      sck_d     = bus.sck;
      ss_d      = bus.ss_L;

      unique case (state_q)
         StIdle: begin
            miso_d = 1'b0;
            if (ss_fall) begin
               request_d = 1'b1;
               err_d     = 1'b0;
               state_d   = StWait;
            end
         end
         StWait: begin
            if (ss_rise) begin
               request_d = 1'b0;
               state_d   = StIdle;
            end else begin
               if (bus.fulfilled) begin
                  shreg_d   = bus.indat;
                  request_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = StShift;
                  if (!PHASE) miso_d = bus.indat[WID-1];
               end
               if (lead || trail) err_d = 1'b1;
            end
         end
         StShift: begin
            if (ss_rise) begin
               err_d   = 1'b1;
               miso_d  = 1'b0;
               state_d = StIdle;
            end else if (!PHASE) begin
               if (trail) begin
                  shreg_d = shreg_q << 1;
                  miso_d  = shreg_q[WID-2];
               end
               if (lead) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == WID_LEN'(WID)) state_d = StDone;
               end
            end else begin
               if (lead) begin
                  miso_d  = shreg_q[WID-1];
                  shreg_d = shreg_q << 1;
               end
               if (trail) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc == WID_LEN'(WID)) state_d = StDone;
               end
            end
         end
         StDone: begin
            if (ss_rise) begin
               miso_d  = 1'b0;
               state_d = StIdle;
            end else if (lead || (PHASE && trail)) begin
               // In CPHA=0 the trailing edge of the last pulse still belongs to the word.
               err_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state_q   <= StIdle;
         shreg_q   <= '0;
         cnt_q     <= '0;
         request_q <= 1'b0;
         err_q     <= 1'b0;
         miso_q    <= 1'b0;
         sck_q     <= POLARITY;
         ss_q      <= 1'b1;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         request_q <= request_d;
         err_q     <= err_d;
         miso_q    <= miso_d;
         sck_q     <= sck_d;
         ss_q      <= ss_d;
      end
   end

   assign bus.request = request_q;
   assign bus.err     = err_q;
   assign bus.miso    = miso_q;

endmodule

// File: tb/tb_adc_spi_sim.sv
// Directed bench: a mode-0 and a mode-3 instance share one SPI master (mode 3 sees
// the inverted clock) and are checked against hand-computed words and flags.
module tb_adc_spi_sim;

   logic        clk = 1'b0;
   logic        rst_L;
   logic        sck, ss_l, fulfilled;
   logic [17:0] indat0, indat3;
   logic [17:0] rd0, rd3;
   int          n_checks = 0;
   int          n_pass   = 0;

   adc_spi_sim_if #(.WID(18)) if0 ();
   adc_spi_sim_if #(.WID(18)) if3 ();

   assign if0.sck       = sck;
   assign if0.ss_L      = ss_l;
   assign if0.fulfilled = fulfilled;
   assign if0.indat     = indat0;
   assign if3.sck       = ~sck;
   assign if3.ss_L      = ss_l;
   assign if3.fulfilled = fulfilled;
   assign if3.indat     = indat3;

   adc_spi_sim #(.WID(18), .WID_LEN(5), .POLARITY(1'b0), .PHASE(1'b0)) u_dut0 (
      .clk   (clk),
      .rst_L (rst_L),
      .bus   (if0)
   );

   adc_spi_sim #(.WID(18), .WID_LEN(5), .POLARITY(1'b1), .PHASE(1'b1)) u_dut3 (
      .clk   (clk),
      .rst_L (rst_L),
      .bus   (if3)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic give_data();
      @(negedge clk) fulfilled = 1'b1;
      @(negedge clk) fulfilled = 1'b0;
   endtask

   // Each sck phase lasts 2 clk; miso is sampled as the master's sampling edge is driven.
   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rd0 = {rd0[16:0], if0.miso};
         sck = 1'b1;
         step(2);
         rd3 = {rd3[16:0], if3.miso};
         sck = 1'b0;
         step(1);
      end
   endtask

   initial begin
      rst_L = 1'b0; ss_l = 1'b1; sck = 1'b0; fulfilled = 1'b0;
      indat0 = '0; indat3 = '0; rd0 = '0; rd3 = '0;
      step(3);
      check("reset_request", 32'(if0.request), 32'd0);
      check("reset_err",     32'(if0.err),     32'd0);
      check("reset_miso",    32'(if0.miso),    32'd0);
      rst_L = 1'b1;
      step(2);

      // Mode 0 / mode 3 normal transfers
      indat0 = 18'h2A5C3; indat3 = 18'h20001;
      ss_l = 1'b0;
      step(1);
      check("m0_request_rise", 32'(if0.request), 32'd1);
      check("m3_request_rise", 32'(if3.request), 32'd1);
      give_data();
      check("m0_request_fall", 32'(if0.request), 32'd0);
      check("m0_first_miso",   32'(if0.miso),    32'd1);
      step(1);
      pulses(18);
      step(2);
      check("m0_word", 32'(rd0), 32'h2A5C3);
      check("m3_word", 32'(rd3), 32'h20001);
      check("m0_err",  32'(if0.err), 32'd0);
      check("m3_err",  32'(if3.err), 32'd0);
      ss_l = 1'b1;
      step(2);
      check("m0_idle_miso", 32'(if0.miso), 32'd0);

      // sck while waiting for data
      ss_l = 1'b0;
      step(1);
      check("wait_request", 32'(if0.request), 32'd1);
      sck = 1'b1;
      step(2);
      check("wait_sck_err", 32'(if0.err), 32'd1);
      sck = 1'b0;
      step(2);
      ss_l = 1'b1;
      step(2);
      check("err_sticky",     32'(if0.err),     32'd1);
      check("wait_abort_req", 32'(if0.request), 32'd0);
      ss_l = 1'b0;
      step(1);
      check("err_cleared", 32'(if0.err), 32'd0);
      ss_l = 1'b1;
      step(2);

      // Early ss_L rise after 10 bits (next bit would be 1)
      indat0 = 18'h2A5C3;
      ss_l = 1'b0;
      step(1);
      give_data();
      step(1);
      pulses(10);
      step(1);
      check("pre_abort_miso", 32'(if0.miso), 32'd1);
      ss_l = 1'b1;
      step(1);
      check("abort_err",  32'(if0.err),  32'd1);
      check("abort_miso", 32'(if0.miso), 32'd0);
      step(2);

      // Fresh all-ones transfer, then a 19th pulse
      indat0 = 18'h3FFFF;
      ss_l = 1'b0;
      step(1);
      check("fresh_err_clear", 32'(if0.err), 32'd0);
      give_data();
      step(1);
      pulses(18);
      step(2);
      check("ones_word", 32'(rd0), 32'h3FFFF);
      check("ones_err",  32'(if0.err), 32'd0);
      pulses(1);
      step(2);
      check("extra_pulse_err", 32'(if0.err), 32'd1);
      ss_l = 1'b1;
      step(2);

      // Async reset at bit 7
      indat0 = 18'h3FFFF;
      ss_l = 1'b0;
      step(1);
      give_data();
      step(1);
      pulses(7);
      check("pre_reset_miso", 32'(if0.miso), 32'd1);
      rst_L = 1'b0;
      #1;
      check("rst_miso",    32'(if0.miso),    32'd0);
      check("rst_request", 32'(if0.request), 32'd0);
      check("rst_err",     32'(if0.err),     32'd0);
      ss_l = 1'b1;
      step(2);
      rst_L = 1'b1;
      step(2);

      indat0 = 18'h00001;
      ss_l = 1'b0;
      step(1);
      check("post_rst_request", 32'(if0.request), 32'd1);
      give_data();
      step(1);
      pulses(18);
      step(2);
      check("post_rst_word", 32'(rd0), 32'h00001);
      check("post_rst_err",  32'(if0.err), 32'd0);
      ss_l = 1'b1;
      step(2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
